// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control sequencer.
//
//   state      | meaning
//   -----------+-------------------------------------------------
//   FETCH      | read instruction at PC, IR/PC load on mem_ready
//   DECODE     | register read, branch target into ALUOut
//   MEM_ADDR   | effective address = A + sign-ext imm
//   MEM_READ   | data read at ALUOut, held until mem_ready
//   MEM_WB     | MDR -> rt
//   MEM_WRITE  | store B at ALUOut, held until mem_ready
//   EXECUTE    | R-type ALU operation on A, B
//   R_WB       | ALUOut -> rd
//   BRANCH     | compare A, B; PC <- ALUOut when zero
//   JUMP       | PC <- jump target
//   ADDI_EX    | A + sign-ext imm
//   ADDI_WB    | ALUOut -> rt
//   TRAP       | illegal opcode, parked until reset
module mips_multicycle_ctrl #(
  parameter int          STATE_W  = 4,
  parameter logic [5:0]  OP_RTYPE = 6'b000000,
  parameter logic [5:0]  OP_LW    = 6'b100011,
  parameter logic [5:0]  OP_SW    = 6'b101011,
  parameter logic [5:0]  OP_BEQ   = 6'b000100,
  parameter logic [5:0]  OP_J     = 6'b000010,
  parameter logic [5:0]  OP_ADDI  = 6'b001000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_en,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_source,
  output logic               instr_done,
  output logic               trap,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EX   = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_TRAP      = 4'd12
  } state_t;

  state_t cur, nxt;
  logic   trap_q;
  logic   pc_write;
  logic   pc_write_cond;

  // State register and sticky trap flag, set on the transition into TRAP
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur    <= S_FETCH;
      trap_q <= 1'b0;
    end else begin
      cur <= nxt;
      if (nxt == S_TRAP) trap_q <= 1'b1;
    end
  end

  // Next-state and datapath control decode
  always_comb begin
    nxt           = cur;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    instr_done    = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    case (cur)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) nxt = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        if (opcode == OP_LW || opcode == OP_SW) nxt = S_MEM_ADDR;
        else if (opcode == OP_RTYPE)            nxt = S_EXECUTE;
        else if (opcode == OP_BEQ)              nxt = S_BRANCH;
        else if (opcode == OP_J)                nxt = S_JUMP;
        else if (opcode == OP_ADDI)             nxt = S_ADDI_EX;
        else                                    nxt = S_TRAP;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nxt       = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) nxt = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        nxt        = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) nxt = S_FETCH;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        nxt       = S_R_WB;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        nxt        = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
        nxt           = S_FETCH;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
        nxt        = S_FETCH;
      end
      S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nxt       = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        nxt        = S_FETCH;
      end
      S_TRAP: begin
        nxt = S_TRAP;
      end
      default: begin
        nxt = S_FETCH;
      end
    endcase
  end

  assign pc_en = pc_write | (pc_write_cond & zero);
  assign trap  = trap_q;
  assign state = STATE_W'(cur);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: each driven cycle queues the
// expected state and control word, a negedge monitor pops and compares.
module tb_mips_multicycle_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_en, i_or_d, mem_read, mem_write, ir_write, reg_write;
  logic       reg_dst, mem_to_reg, alu_src_a, instr_done, trap;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [3:0]  st;
    logic [16:0] ctrl;
  } exp_t;

  exp_t exp_q[$];

  mips_multicycle_ctrl dut (
    .clock(clock), .reset(reset), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .instr_done(instr_done), .trap(trap),
    .state(state)
  );

  always #5 clock = ~clock;

  wire [16:0] obs_ctrl = {pc_en, ir_write, i_or_d, mem_read, mem_write,
                          reg_write, reg_dst, mem_to_reg, alu_src_a,
                          alu_src_b, alu_op, pc_source, instr_done, trap};

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Control word expected in a given state, written straight from the state table
  function automatic logic [16:0] exp_ctrl(input logic [3:0] st, input logic rdy,
                                           input logic z);
    logic pcw, pcwc, irw, iod, mr, mw, rw, rd, m2r, sa, done, tr;
    logic [1:0] sb, op, ps;
    {pcw, pcwc, irw, iod, mr, mw, rw, rd, m2r, sa, done, tr} = '0;
    sb = 2'b00; op = 2'b00; ps = 2'b00;
    case (st)
      4'd0:  begin mr = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
      4'd1:  sb = 2'b11;
      4'd2:  begin sa = 1; sb = 2'b10; end
      4'd3:  begin mr = 1; iod = 1; end
      4'd4:  begin rw = 1; m2r = 1; done = 1; end
      4'd5:  begin mw = 1; iod = 1; done = rdy; end
      4'd6:  begin sa = 1; op = 2'b10; end
      4'd7:  begin rw = 1; rd = 1; done = 1; end
      4'd8:  begin sa = 1; op = 2'b01; pcwc = 1; ps = 2'b01; done = 1; end
      4'd9:  begin pcw = 1; ps = 2'b10; done = 1; end
      4'd10: begin sa = 1; sb = 2'b10; end
      4'd11: begin rw = 1; done = 1; end
      4'd12: tr = 1;
      default: ;
    endcase
    return {pcw | (pcwc & z), irw, iod, mr, mw, rw, rd, m2r, sa, sb, op, ps, done, tr};
  endfunction

  // Monitor: compare queued expectation against the DUT mid-cycle
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("state", 32'(state), 32'(e.st));
      check($sformatf("ctrl_s%0d", e.st), 32'(obs_ctrl), 32'(e.ctrl));
    end
  end

  // One clock of stimulus: drive mem_ready, queue the expectation, advance
  task automatic cyc(input logic [3:0] st, input logic rdy);
    exp_t e;
    mem_ready = rdy;
    e.st   = st;
    e.ctrl = exp_ctrl(st, rdy, zero);
    exp_q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  // One instruction, expected state path derived from its opcode
  task automatic instr(input logic [5:0] op, input logic z,
                       input int fstall, input int mstall);
    logic r;
    opcode = op;
    zero   = z;
    repeat (fstall) cyc(4'd0, 1'b0);
    cyc(4'd0, 1'b1);
    r = 1'($urandom_range(0, 1));
    cyc(4'd1, r);
    case (op)
      6'b100011: begin
        cyc(4'd2, 1'($urandom_range(0, 1)));
        repeat (mstall) cyc(4'd3, 1'b0);
        cyc(4'd3, 1'b1);
        cyc(4'd4, 1'($urandom_range(0, 1)));
      end
      6'b101011: begin
        cyc(4'd2, 1'($urandom_range(0, 1)));
        repeat (mstall) cyc(4'd5, 1'b0);
        cyc(4'd5, 1'b1);
      end
      6'b000000: begin
        cyc(4'd6, 1'($urandom_range(0, 1)));
        cyc(4'd7, 1'($urandom_range(0, 1)));
      end
      6'b000100: cyc(4'd8, 1'($urandom_range(0, 1)));
      6'b000010: cyc(4'd9, 1'($urandom_range(0, 1)));
      6'b001000: begin
        cyc(4'd10, 1'($urandom_range(0, 1)));
        cyc(4'd11, 1'($urandom_range(0, 1)));
      end
      default: begin
        for (int i = 0; i < 10; i++) begin
          zero = 1'($urandom_range(0, 1));
          cyc(4'd12, 1'($urandom_range(0, 1)));
        end
      end
    endcase
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_trap", 32'(trap), 32'd0);
    check("rst_reg_write", 32'(reg_write), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    opcode    = 6'b0;
    zero      = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_trap", 32'(trap), 32'd0);
    check("rst_ctrl", 32'(obs_ctrl), 32'(exp_ctrl(4'd0, 1'b0, 1'b0)));
    reset = 1'b0;

    instr(6'b000000, 1'b0, 0, 0);   // R-type
    instr(6'b100011, 1'b0, 0, 2);   // LW, two stall cycles in MEM_READ
    instr(6'b100011, 1'b1, 0, 0);   // LW, no stall
    instr(6'b101011, 1'b0, 0, 1);   // SW, one stall
    instr(6'b101011, 1'b0, 0, 0);
    instr(6'b000100, 1'b1, 0, 0);   // BEQ taken
    instr(6'b000100, 1'b0, 0, 0);   // BEQ not taken
    instr(6'b000010, 1'b0, 0, 0);   // J
    instr(6'b001000, 1'b1, 0, 0);   // ADDI
    instr(6'b000010, 1'b1, 3, 0);   // FETCH stalled 3 cycles
    instr(6'b000000, 1'b1, 1, 0);

    // Reset mid-EXECUTE: asynchronous, no partial writeback afterwards
    opcode = 6'b000000;
    cyc(4'd0, 1'b1);
    cyc(4'd1, 1'b1);
    check("pre_rst_state", 32'(state), 32'd6);
    #2;
    do_reset();
    cyc(4'd0, 1'b0);
    instr(6'b001000, 1'b0, 0, 0);

    // Illegal opcode: trap, sticky for 10 cycles, cleared by reset
    instr(6'b111111, 1'b0, 0, 0);
    check("trap_sticky", 32'(trap), 32'd1);
    do_reset();
    instr(6'b100011, 1'b0, 1, 1);

    @(negedge clock);
    #1;
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
